// File: rtl/emb_fetch.sv
// Embedding lookup initiator: turns one character index into EMB_DIM sequential
// ROM reads and packs the returned words into a single embedding vector.
module emb_fetch #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 13,
    parameter int EMB_DIM  = 24,
    parameter int CHAR_NUM = 200,
    parameter int IWIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IWIDTH-1:0]         in_char,
    output logic [AWIDTH-1:0]         rom_addr,
    input  logic [DWIDTH-1:0]         rom_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EMB_DIM*DWIDTH-1:0] out_vec,
    output logic                      out_err
);

    localparam int KW = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1;
    localparam logic [KW-1:0]     LAST_IDX = KW'(EMB_DIM - 1);
    localparam logic [AWIDTH-1:0] DIM_A    = AWIDTH'(EMB_DIM);
    localparam logic [31:0]       CHAR_LIM = 32'(CHAR_NUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [AWIDTH-1:0] base_r;
    logic [KW-1:0]     issue_idx_r;
    logic [KW-1:0]     write_idx_r;
    logic              capture_r;
    logic              char_ok_s;

    // Range check of the offered index, widened so any IWIDTH compares correctly
    always_comb begin
        char_ok_s = 1'b0;
        if (32'(in_char) < CHAR_LIM) begin
            char_ok_s = 1'b1;
        end else begin
            char_ok_s = 1'b0;
        end
    end

    // Transaction FSM; capture trails issue by one cycle because rom_q answers the previous address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready    <= 1'b1;
            rom_addr    <= '0;
            out_valid   <= 1'b0;
            out_vec     <= '0;
            out_err     <= 1'b0;
            base_r      <= '0;
            issue_idx_r <= '0;
            write_idx_r <= '0;
            capture_r   <= 1'b0;
        end else begin
            if (capture_r) begin
                out_vec[int'(write_idx_r)*DWIDTH +: DWIDTH] <= rom_q;
            end
            case (state_r)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (char_ok_s) begin
                            base_r      <= AWIDTH'(in_char) * DIM_A;
                            issue_idx_r <= '0;
                            out_err     <= 1'b0;
                            state_r     <= FETCH;
                        end else begin
                            out_vec   <= '0;
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            state_r   <= DONE;
                        end
                    end
                end
                FETCH: begin
                    rom_addr    <= base_r + AWIDTH'(issue_idx_r);
                    write_idx_r <= issue_idx_r;
                    capture_r   <= 1'b1;
                    issue_idx_r <= issue_idx_r + KW'(1);
                    if (issue_idx_r == LAST_IDX) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    capture_r <= 1'b0;
                    out_valid <= 1'b1;
                    state_r   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    capture_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emb_fetch.sv
// Directed bench for emb_fetch with a ROM model holding mem[i] = i, so the
// expected element d of character c is simply c*24 + d.
module tb_emb_fetch;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int ED = 24;
    localparam int VW = ED * DW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_char;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_vec;
    logic          out_err;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int n_checks;
    int n_errors;

    emb_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_err   (out_err)
    );

    // Registered address from the DUT is the ROM's address register
    assign rom_q = mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] exp_vec(input int base);
        logic [VW-1:0] v;
        v = '0;
        for (int d = 0; d < ED; d++) v[d*DW +: DW] = 16'(base + d);
        return v;
    endfunction

    // Offers one index at a negedge; returns at the negedge where out_valid is first seen.
    // lat counts rising edges from the handshake edge to the edge that first samples out_valid.
    task automatic run_txn(input logic [7:0] ch, input logic rdy, input int base,
                           output int lat, output logic addr_ok, output int max_addr);
        int w;
        out_ready = rdy;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        in_char  = ch;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        addr_ok  = 1'b1;
        max_addr = 0;
        lat      = -1;
        for (int e = 0; e < 60; e++) begin
            if (e >= 1 && e <= ED) begin
                if (int'(rom_addr) != base + e - 1) addr_ok = 1'b0;
                if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            end
            if (out_valid) begin
                lat = e + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    int            lat;
    logic          aok;
    int            maxa;
    logic [AW-1:0] addr_before;
    logic [VW-1:0] held_vec;
    logic          stable;
    logic          rdy_low;
    logic [7:0]    b2b_char [0:2];
    logic [VW-1:0] b2b_vec [0:2];
    logic          b2b_err [0:2];
    int            b2b_idx;
    int            b2b_res;
    logic          hs_pending;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = 16'(i);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'd0;
        out_ready = 1'b0;
        #1;
        check_eq("rst_in_ready", VW'(in_ready), VW'(1'b1));
        check_eq("rst_rom_addr", VW'(rom_addr), VW'(0));
        check_eq("rst_out_valid", VW'(out_valid), VW'(1'b0));
        check_eq("rst_out_vec", out_vec, '0);
        check_eq("rst_out_err", VW'(out_err), VW'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // char 0: addresses 0..23, elements 0..23
        run_txn(8'd0, 1'b1, 0, lat, aok, maxa);
        check_eq("c0_latency", VW'(lat), VW'(26));
        check_eq("c0_addr_seq", VW'(aok), VW'(1'b1));
        check_eq("c0_vec", out_vec, exp_vec(0));
        check_eq("c0_err", VW'(out_err), VW'(1'b0));
        @(negedge clk);

        // last legal char: addresses 4776..4799
        run_txn(8'd199, 1'b1, 4776, lat, aok, maxa);
        check_eq("c199_latency", VW'(lat), VW'(26));
        check_eq("c199_addr_seq", VW'(aok), VW'(1'b1));
        check_eq("c199_max_addr", VW'(maxa), VW'(4799));
        check_eq("c199_vec", out_vec, exp_vec(4776));
        check_eq("c199_err", VW'(out_err), VW'(1'b0));
        @(negedge clk);

        // out-of-range indices
        addr_before = rom_addr;
        run_txn(8'd200, 1'b1, 0, lat, aok, maxa);
        check_eq("c200_latency", VW'(lat), VW'(1));
        check_eq("c200_err", VW'(out_err), VW'(1'b1));
        check_eq("c200_vec", out_vec, '0);
        check_eq("c200_addr_hold", VW'(rom_addr), VW'(addr_before));
        @(negedge clk);
        run_txn(8'd255, 1'b1, 0, lat, aok, maxa);
        check_eq("c255_latency", VW'(lat), VW'(1));
        check_eq("c255_err", VW'(out_err), VW'(1'b1));
        check_eq("c255_vec", out_vec, '0);
        check_eq("c255_addr_hold", VW'(rom_addr), VW'(addr_before));
        @(negedge clk);

        // back-pressure: result held for 10 cycles
        run_txn(8'd2, 1'b0, 48, lat, aok, maxa);
        check_eq("hold_vec", out_vec, exp_vec(48));
        held_vec = out_vec;
        stable   = 1'b1;
        rdy_low  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || out_vec !== held_vec || out_err !== 1'b0) stable = 1'b0;
            if (in_ready !== 1'b0) rdy_low = 1'b0;
        end
        check_eq("hold_stable", VW'(stable), VW'(1'b1));
        check_eq("hold_in_ready_low", VW'(rdy_low), VW'(1'b1));
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("hold_consumed", VW'(out_valid), VW'(1'b0));
        check_eq("hold_in_ready_back", VW'(in_ready), VW'(1'b1));

        // reset during the 10th FETCH cycle of char 5
        in_char  = 8'd5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", VW'(out_valid), VW'(1'b0));
        check_eq("midrst_out_vec", out_vec, '0);
        check_eq("midrst_in_ready", VW'(in_ready), VW'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        run_txn(8'd7, 1'b1, 168, lat, aok, maxa);
        check_eq("c7_latency", VW'(lat), VW'(26));
        check_eq("c7_vec", out_vec, exp_vec(168));
        check_eq("c7_err", VW'(out_err), VW'(1'b0));
        @(negedge clk);

        // back-to-back with in_valid held high
        b2b_char[0] = 8'd3;   b2b_vec[0] = exp_vec(72);  b2b_err[0] = 1'b0;
        b2b_char[1] = 8'd4;   b2b_vec[1] = exp_vec(96);  b2b_err[1] = 1'b0;
        b2b_char[2] = 8'd201; b2b_vec[2] = '0;           b2b_err[2] = 1'b1;
        b2b_idx    = 0;
        b2b_res    = 0;
        hs_pending = 1'b0;
        out_ready  = 1'b1;
        in_char    = b2b_char[0];
        in_valid   = 1'b1;
        for (int c = 0; c < 200 && b2b_res < 3; c++) begin
            if (hs_pending) begin
                hs_pending = 1'b0;
                b2b_idx++;
                if (b2b_idx < 3) in_char = b2b_char[b2b_idx];
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                check_eq($sformatf("b2b_vec%0d", b2b_res), out_vec, b2b_vec[b2b_res]);
                check_eq($sformatf("b2b_err%0d", b2b_res), VW'(out_err), VW'(b2b_err[b2b_res]));
                b2b_res++;
            end
            if (in_ready && in_valid) hs_pending = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("b2b_result_count", VW'(b2b_res), VW'(3));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/emb_fetch.md
Name: emb_fetch

Overview:
- Lookup initiator for the synchronous embedding weight ROM (1-cycle read latency, one DWIDTH word per address, row-major: address = char*EMB_DIM + dim).
- Accepts one character index per transaction over a valid/ready handshake.
- Issues EMB_DIM consecutive ROM reads and assembles the returned words into one packed embedding vector for the downstream layer.

Parameters:
- DWIDTH, 16, width of one embedding element (= `N_LEN)
- AWIDTH, 13, ROM address width
- EMB_DIM, 24, elements per embedding vector (= `EMB_DIM)
- CHAR_NUM, 200, number of valid character indices (= `CHAR_NUM)
- IWIDTH, 8, width of character index input

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  character index valid
- in_ready  output  1  block can accept an index
- in_char  input  IWIDTH  character index
- rom_addr  output  AWIDTH  address to embedding ROM
- rom_q  input  DWIDTH  ROM data, valid 1 cycle after rom_addr
- out_valid  output  1  out_vec/out_err valid
- out_ready  input  1  downstream accepts result
- out_vec  output  EMB_DIM*DWIDTH  packed embedding; element d at bits [d*DWIDTH +: DWIDTH]
- out_err  output  1  index was >= CHAR_NUM

Behaviour:
- Reset values (async, immediate): state=IDLE, in_ready=1, rom_addr=0, out_valid=0, out_vec=0, out_err=0, all counters=0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - Handshake is in_valid & in_ready at a rising edge.
  - Valid index (< CHAR_NUM): latch base=in_char*EMB_DIM, set issue count=0, clear out_err, go to FETCH.
  - Index >= CHAR_NUM: out_vec=0, out_err=1, no ROM reads, go to DONE.
- FETCH:
  - in_ready=0.
  - Each cycle drive rom_addr=base+k for k=0..EMB_DIM-1 (registered output), then increment k.
  - Data from address base+k is captured one cycle later into element k.
  - After k=EMB_DIM-1 is issued, go to DRAIN.
- DRAIN: one cycle; capture the last element (EMB_DIM-1), then go to DONE.
- DONE:
  - out_valid=1. out_vec and out_err are held stable until out_ready.
  - On out_valid & out_ready: out_valid=0, go to IDLE.
  - in_ready stays 0 in DONE; there is no overlap of transactions.
- Capture uses a separate registered write index that lags the issue index by one cycle. Elements are written only by capture; there is no clearing between valid transactions except on an error, which zeroes the vector.
- Latency, valid index: handshake at edge T → rom_addr=base at T+1 … base+EMB_DIM-1 at T+EMB_DIM → out_valid at edge T+EMB_DIM+2 (T+26 at defaults).
- Latency, invalid index: out_valid at T+1.
- Throughput: one vector per EMB_DIM+3 cycles minimum.
- Arithmetic: base computed in AWIDTH bits. Max address (CHAR_NUM-1)*EMB_DIM+EMB_DIM-1 = 4799 must be < 2^AWIDTH; this is a parameter constraint, not checked at runtime.
- rom_addr holds its last value in IDLE/DRAIN/DONE; only the FETCH-cycle values are meaningful.
- in_char and in_valid are ignored outside IDLE. out_ready is ignored outside DONE.
- Reset asserted mid-FETCH/DRAIN/DONE: immediate return to reset values. No partial result is ever presented; the pending transaction is dropped.
- out_ready held high in DONE: out_valid lasts exactly one cycle. A new in_valid may be accepted on the next cycle in IDLE.

Test Plan:
- Reset then in_char=0 with ROM model preloaded mem[i]=i → out_vec elements 0..23 = 0..23, out_err=0, out_valid at handshake+26, rom_addr sequence 0..23 on consecutive cycles.
- in_char=199 → rom_addr 4776..4799 issued; out_vec element d = 4776+d; no address exceeds 4799.
- in_char=200 and in_char=255 → out_valid next cycle, out_err=1, out_vec=0, rom_addr never leaves its previous value.
- out_ready held 0 for 10 cycles in DONE → out_valid, out_vec and out_err stable; in_ready=0 throughout; result consumed on the first out_ready=1.
- Assert rst at 10th FETCH cycle of in_char=5 → next cycle state IDLE, out_valid=0, out_vec=0. A following in_char=7 returns elements 168..191 with no stale data.
- Back-to-back: in_valid held 1 with indices 3, 4, 201 and out_ready=1 → three results in order (72..95, 96..119, error), each accepted only when in_ready=1.
